// File: rtl/spi_sample_sequencer.sv
// SPI sample sequencer: assembles DATA_WIDTH-bit words from edge-detector pulses
// inside a chip-select frame and hands them out through a one-word buffer.
// Optional: SPI_SEQ_PARTIAL_FLUSH_EN delivers zero-padded partial words on cs_end.
module spi_sample_sequencer #(
  parameter int DATA_WIDTH     = 8,
  parameter int SAMPLE_ON_FALL = 0,
  parameter int MSB_FIRST      = 1,
  localparam int CW            = $clog2(DATA_WIDTH+1)
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  cs_start,
  input  logic                  cs_end,
  input  logic                  sclk_rise,
  input  logic                  sclk_fall,
  input  logic                  data_in,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  frame_active,
  output logic [CW-1:0]         bit_cnt,
`ifdef SPI_SEQ_PARTIAL_FLUSH_EN
  output logic                  rx_partial,
`endif
  output logic                  overrun
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg;
  logic [DATA_WIDTH-1:0] word_next;
  logic [CW-1:0]         pos;
  logic                  sample;
  logic                  buf_free;

  assign sample   = (SAMPLE_ON_FALL != 0) ? sclk_fall : sclk_rise;
  assign buf_free = !rx_valid || rx_ready;
  assign pos      = (MSB_FIRST != 0) ? CW'(DATA_WIDTH-1) - bit_cnt : bit_cnt;

  // Bits are written in place rather than shifted, so a partial word is
  // already zero-padded in its unfilled positions.
  always_comb begin
    word_next = shreg;
    for (int i = 0; i < DATA_WIDTH; i++)
      if (pos == CW'(i)) word_next[i] = data_in;
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shreg        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      frame_active <= 1'b0;
      bit_cnt      <= '0;
      overrun      <= 1'b0;
`ifdef SPI_SEQ_PARTIAL_FLUSH_EN
      rx_partial   <= 1'b0;
`endif
    end else begin
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (en && cs_start && !cs_end) begin
            state        <= ACTIVE;
            frame_active <= 1'b1;
            bit_cnt      <= '0;
            shreg        <= '0;
          end
        end
        ACTIVE: begin
          if (cs_end || !en) begin
            state        <= IDLE;
            frame_active <= 1'b0;
            bit_cnt      <= '0;
            shreg        <= '0;
`ifdef SPI_SEQ_PARTIAL_FLUSH_EN
            if (cs_end && bit_cnt != '0) begin
              if (buf_free) begin
                rx_data    <= shreg;
                rx_valid   <= 1'b1;
                rx_partial <= 1'b1;
              end else begin
                overrun    <= 1'b1;
              end
            end
`endif
          end else if (cs_start) begin
            bit_cnt <= '0;
            shreg   <= '0;
          end else if (sample) begin
            if (bit_cnt == CW'(DATA_WIDTH-1)) begin
              bit_cnt <= '0;
              shreg   <= '0;
              // Free buffer includes a same-cycle consume, so no bubble.
              if (buf_free) begin
                rx_data    <= word_next;
                rx_valid   <= 1'b1;
`ifdef SPI_SEQ_PARTIAL_FLUSH_EN
                rx_partial <= 1'b0;
`endif
              end else begin
                overrun    <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              shreg   <= word_next;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sample_sequencer.sv
// Directed bench for spi_sample_sequencer: a vector table for the main flows
// plus hand-written sequences for abort, back-to-back handshake and async reset.
module tb_spi_sample_sequencer;

  logic sys_clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0, cs_start = 1'b0, cs_end = 1'b0;
  logic sclk_rise = 1'b0, sclk_fall = 1'b0, data_in = 1'b0, rx_ready = 1'b0;

  logic [7:0] rx_data, rx_data2;
  logic       rx_valid, rx_valid2, frame_active, frame_active2, overrun, overrun2;
  logic [3:0] bit_cnt, bit_cnt2;
`ifdef SPI_SEQ_PARTIAL_FLUSH_EN
  logic       rx_partial, rx_partial2;
`endif

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  spi_sample_sequencer dut (
    .sys_clk(sys_clk), .rst_n(rst_n), .en(en), .cs_start(cs_start), .cs_end(cs_end),
    .sclk_rise(sclk_rise), .sclk_fall(sclk_fall), .data_in(data_in),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .frame_active(frame_active), .bit_cnt(bit_cnt),
`ifdef SPI_SEQ_PARTIAL_FLUSH_EN
    .rx_partial(rx_partial),
`endif
    .overrun(overrun)
  );

  // LSB-first, falling-edge variant sharing the same stimulus.
  spi_sample_sequencer #(.DATA_WIDTH(8), .SAMPLE_ON_FALL(1), .MSB_FIRST(0)) dut2 (
    .sys_clk(sys_clk), .rst_n(rst_n), .en(en), .cs_start(cs_start), .cs_end(cs_end),
    .sclk_rise(sclk_rise), .sclk_fall(sclk_fall), .data_in(data_in),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .rx_ready(rx_ready),
    .frame_active(frame_active2), .bit_cnt(bit_cnt2),
`ifdef SPI_SEQ_PARTIAL_FLUSH_EN
    .rx_partial(rx_partial2),
`endif
    .overrun(overrun2)
  );

  typedef struct {
    logic       cs_s, cs_e, rise, fall, din, rdy;
    logic       ev;
    logic [7:0] ed;
    logic       eo;
    logic [3:0] ebc;
    logic       ea;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic cs_s, cs_e, rise, fall, din, rdy,
                     input logic ev, input logic [7:0] ed, input logic eo,
                     input logic [3:0] ebc, input logic ea);
    vec_t v;
    v.cs_s = cs_s; v.cs_e = cs_e; v.rise = rise; v.fall = fall; v.din = din; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.eo = eo; v.ebc = ebc; v.ea = ea;
    tbl.push_back(v);
  endtask

  // One MSB-first byte on sclk_rise; outputs hold ev/ed/eo until the last bit,
  // which produces xv/xd/xo.
  task automatic add_byte(input logic [7:0] b, input logic rdy,
                          input logic ev, input logic [7:0] ed, input logic eo,
                          input logic xv, input logic [7:0] xd, input logic xo);
    for (int i = 0; i < 8; i++) begin
      if (i < 7) add(0, 0, 1, 0, b[7-i], rdy, ev, ed, eo, 4'(i+1), 1);
      else       add(0, 0, 1, 0, b[7-i], rdy, xv, xd, xo, 4'd0, 1);
    end
  endtask

  task automatic step(input logic cs_s, cs_e, rise, fall, din, rdy);
    cs_start = cs_s; cs_end = cs_e; sclk_rise = rise; sclk_fall = fall;
    data_in = din; rx_ready = rdy;
    @(posedge sys_clk);
    #1;
    cs_start = 1'b0; cs_end = 1'b0; sclk_rise = 1'b0; sclk_fall = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic rdy);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, b[7-i], rdy);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    // Table: A5 with fall pulse ignored, then two words into a stalled buffer.
    add(0, 0, 0, 0, 0, 0, 0, 8'h00, 0, 4'd0, 0);
    add(1, 0, 0, 0, 0, 1, 0, 8'h00, 0, 4'd0, 1);
    add(0, 0, 1, 0, 1, 1, 0, 8'h00, 0, 4'd1, 1);
    add(0, 0, 1, 0, 0, 1, 0, 8'h00, 0, 4'd2, 1);
    add(0, 0, 1, 0, 1, 1, 0, 8'h00, 0, 4'd3, 1);
    add(0, 0, 0, 1, 1, 1, 0, 8'h00, 0, 4'd3, 1);
    add(0, 0, 1, 0, 0, 1, 0, 8'h00, 0, 4'd4, 1);
    add(0, 0, 1, 0, 0, 1, 0, 8'h00, 0, 4'd5, 1);
    add(0, 0, 1, 0, 1, 1, 0, 8'h00, 0, 4'd6, 1);
    add(0, 0, 1, 0, 0, 1, 0, 8'h00, 0, 4'd7, 1);
    add(0, 0, 1, 0, 1, 1, 1, 8'hA5, 0, 4'd0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 8'hA5, 0, 4'd0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 8'hA5, 0, 4'd0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 8'hA5, 0, 4'd0, 1);
    add_byte(8'h11, 0, 0, 8'hA5, 0, 1, 8'h11, 0);
    add_byte(8'h22, 0, 1, 8'h11, 0, 1, 8'h11, 1);
    add(0, 0, 0, 0, 0, 1, 0, 8'h11, 1, 4'd0, 1);
    add(0, 1, 0, 0, 0, 0, 0, 8'h11, 1, 4'd0, 0);

    en = 1'b1;
    #2;
    chk("reset_valid", rx_valid, 0);
    chk("reset_data", rx_data, 0);
    chk("reset_active", frame_active, 0);
    chk("reset_overrun", overrun, 0);
    rst_n = 1'b1;
    @(posedge sys_clk);
    #1;

    for (int r = 0; r < tbl.size(); r++) begin
      step(tbl[r].cs_s, tbl[r].cs_e, tbl[r].rise, tbl[r].fall, tbl[r].din, tbl[r].rdy);
      chk($sformatf("tbl%0d_valid", r), rx_valid, tbl[r].ev);
      chk($sformatf("tbl%0d_data", r), rx_data, tbl[r].ed);
      chk($sformatf("tbl%0d_overrun", r), overrun, tbl[r].eo);
      chk($sformatf("tbl%0d_bitcnt", r), bit_cnt, tbl[r].ebc);
      chk($sformatf("tbl%0d_active", r), frame_active, tbl[r].ea);
    end

    // Abort after 5 bits (sample coinciding with cs_end is ignored), then 3C.
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    chk("abort_bitcnt5", bit_cnt, 5);
    step(0, 1, 1, 0, 1, 0);
    chk("abort_bitcnt0", bit_cnt, 0);
    chk("abort_active", frame_active, 0);
`ifdef SPI_SEQ_PARTIAL_FLUSH_EN
    chk("flush_valid", rx_valid, 1);
    chk("flush_data", rx_data, 8'hB8);
    chk("flush_partial", rx_partial, 1);
    step(0, 0, 0, 0, 0, 1);
`else
    chk("abort_valid", rx_valid, 0);
`endif
    step(1, 0, 1, 0, 1, 0);
    chk("restart_bitcnt", bit_cnt, 0);
    send_byte(8'h3C, 0);
    chk("abort_next_valid", rx_valid, 1);
    chk("abort_next_data", rx_data, 8'h3C);
    chk("abort_next_overrun", overrun, 0);
`ifdef SPI_SEQ_PARTIAL_FLUSH_EN
    chk("full_partial", rx_partial, 0);
`endif

    // Word completes in the cycle the previous word is accepted.
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    send_byte(8'h11, 0);
    chk("b2b_first", rx_data, 8'h11);
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 1, 0, i == 2 || i == 6, 0);
      chk($sformatf("b2b_hold%0d", i), rx_valid, 1);
    end
    step(0, 0, 1, 0, 0, 1);
    chk("b2b_valid", rx_valid, 1);
    chk("b2b_data", rx_data, 8'h22);
    chk("b2b_overrun", overrun, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("b2b_drained", rx_valid, 0);

    // LSB-first on falling edges; the default instance ignores these pulses.
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 1, 0);
    chk("lsb_rise_ignored", bit_cnt2, 2);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 0, 0);
    chk("lsb_valid", rx_valid2, 1);
    chk("lsb_data", rx_data2, 8'h03);
    chk("msb_fall_ignored", bit_cnt, 1);

    // Asynchronous reset mid-frame with a buffered word.
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    send_byte(8'h5A, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 1, 0);
    chk("pre_rst_bitcnt", bit_cnt, 4);
    chk("pre_rst_valid", rx_valid, 1);
    rst_n = 1'b0;
    #2;
    chk("arst_valid", rx_valid, 0);
    chk("arst_data", rx_data, 0);
    chk("arst_bitcnt", bit_cnt, 0);
    chk("arst_active", frame_active, 0);
    chk("arst_overrun", overrun, 0);
    #1;
    rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    step(1, 0, 0, 0, 0, 0);
    chk("post_rst_active", frame_active, 1);
    send_byte(8'hA5, 0);
    chk("post_rst_data", rx_data, 8'hA5);
    chk("post_rst_valid", rx_valid, 1);
    chk("post_rst_overrun", overrun, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_sample_sequencer.md
Name: spi_sample_sequencer

Overview:
Sequences the sampling of a serial data line using the single-cycle edge pulses produced by the edge detectors on the chip-select and serial-clock lines. It assembles DATA_WIDTH-bit words inside a chip-select frame and hands each complete word to the downstream MITM logic over a valid/ready handshake. It has a one-word output buffer and reports overrun when that buffer is full. It sits between the edge detector instances and the frame/packet handling logic of the interception path.

Parameters:
DATA_WIDTH, 8, bits per assembled word (2..32)
SAMPLE_ON_FALL, 0, 0 = sample data_in on sclk_rise pulse; 1 = sample on sclk_fall pulse
MSB_FIRST, 1, 1 = first sampled bit lands in word MSB; 0 = first bit lands in LSB

Ports:
sys_clk  in  1  system clock; all inputs synchronous to it
rst_n  in  1  asynchronous reset, active-low
en  in  1  sequencer enable; 0 forces IDLE on next edge, buffer kept
cs_start  in  1  one-cycle pulse, chip-select became active
cs_end  in  1  one-cycle pulse, chip-select became inactive
sclk_rise  in  1  one-cycle pulse, serial clock rising edge
sclk_fall  in  1  one-cycle pulse, serial clock falling edge
data_in  in  1  synchronized serial data line
rx_data  out  DATA_WIDTH  buffered word
rx_valid  out  1  rx_data holds an unconsumed word
rx_ready  in  1  consumer accepts word when rx_valid & rx_ready
frame_active  out  1  high while in ACTIVE state
bit_cnt  out  $clog2(DATA_WIDTH+1)  bits collected in current word
overrun  out  1  sticky; a completed word was dropped

Behaviour:
- Reset (rst_n=0, asynchronous): state IDLE, shift register 0, rx_data 0, rx_valid 0, frame_active 0, bit_cnt 0, overrun 0.
- States: IDLE, ACTIVE.
- IDLE -> ACTIVE: cs_start=1 and en=1; bit_cnt cleared, shift register cleared.
- ACTIVE -> IDLE: cs_end=1 or en=0; partial word discarded, bit_cnt cleared.
- cs_start in ACTIVE: frame restarts; bit_cnt cleared, partial discarded, state stays ACTIVE.
- cs_start and cs_end in the same cycle: cs_end wins; next state IDLE.
- Sample edge = sclk_fall if SAMPLE_ON_FALL else sclk_rise. The other clock pulse is ignored.
- Sample edge in ACTIVE with no cs_end that cycle: data_in is shifted in at the position given by MSB_FIRST, and bit_cnt increments.
- A sample edge in the same cycle as cs_end or cs_start is ignored.
- Word complete: sample edge while bit_cnt = DATA_WIDTH-1. Next cycle:
  - bit_cnt = 0.
  - If the buffer is free, the word is loaded into rx_data and rx_valid=1. Latency is 1 cycle from the completing pulse to rx_valid.
  - The buffer counts as free if rx_valid=0, or if rx_valid & rx_ready in the completing cycle (simultaneous consume and load; no bubble).
  - Otherwise the word is dropped, overrun is set, and rx_data is unchanged.
- Handshake: rx_data is stable while rx_valid=1 and not accepted. rx_valid clears the cycle after acceptance unless a reload occurs.
- overrun stays set until reset.
- en=0 does not clear rx_valid or rx_data; the consumer may still drain the buffer.
- Pulses are single-cycle. Back-to-back sample pulses in consecutive cycles are each processed.

Optional Feature:
Macro SPI_SEQ_PARTIAL_FLUSH_EN.
- Defined:
  - cs_end in ACTIVE with 0 < bit_cnt < DATA_WIDTH delivers the partial word, zero-padded in the unfilled positions, through the same buffer and overrun rules.
  - An extra output rx_partial (1 bit) qualifies rx_data and is updated together with rx_data. It is 0 on reset.
- Undefined: partial words are silently discarded, and the rx_partial port does not exist.

Test Plan:
- Default params; cs_start, then 8 sclk_rise pulses with data_in = 1,0,1,0,0,1,0,1, rx_ready=1 -> rx_data=8'hA5, rx_valid for exactly 1 cycle, starting 1 cycle after the 8th pulse; overrun=0.
- MSB_FIRST=0, same bits -> rx_data=8'hA5 bit-reversed = 8'hA5 sequence read LSB-first = 8'hA5 with bit0=1 first, i.e. 8'hA5 -> 8'hA5? Use data_in = 1,1,0,0,0,0,0,0 instead -> rx_data=8'h03.
- rx_ready=0; send two full words 8'h11 then 8'h22 -> rx_data stays 8'h11, rx_valid=1, overrun=1 after the second word. Then rx_ready=1 -> 8'h11 is consumed and rx_valid=0.
- cs_end after 5 bits, then cs_start and 8 bits of 8'h3C -> only 8'h3C is delivered; bit_cnt returns to 0 on cs_end. With SPI_SEQ_PARTIAL_FLUSH_EN, 5 bits 1,0,1,1,1 first deliver rx_data=8'hB8 with rx_partial=1.
- Word completes in the same cycle that the previous word is accepted -> new word loaded with no overrun and rx_valid held continuously high.
- rst_n pulled low mid-frame (bit_cnt=4, rx_valid=1) -> all outputs immediately 0. After release, the next cs_start starts a clean frame.
